// File: rtl/regfile_scoreboard_if.sv
// ----------------------------------------------------------------------------
// regfile_scoreboard_if
//
// Bundles every non-clock/reset signal of the register file + scoreboard
// into one interface.
//
//   Writeback : reg_write, write_register, write_data        (master -> slave)
//   Read ports: read_register1/2 (master -> slave),
//               read_data1/2 (slave -> master, combinational)
//   Issue     : issue_valid, issue_writes, issue_dest,
//               issue_src1, issue_src2                       (master -> slave)
//   Hazard    : stall (combinational), busy_mask, pending_count
//               (registered)                                 (slave -> master)
//
// The slave modport is used by the register file. The master modport is
// used by whatever drives writeback and issue.
// ----------------------------------------------------------------------------
interface regfile_scoreboard_if #(
  parameter int WIDTH  = 32,
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5
);

  logic              reg_write;
  logic [ADDR_W-1:0] write_register;
  logic [WIDTH-1:0]  write_data;

  logic [ADDR_W-1:0] read_register1;
  logic [ADDR_W-1:0] read_register2;
  logic [WIDTH-1:0]  read_data1;
  logic [WIDTH-1:0]  read_data2;

  logic              issue_valid;
  logic              issue_writes;
  logic [ADDR_W-1:0] issue_dest;
  logic [ADDR_W-1:0] issue_src1;
  logic [ADDR_W-1:0] issue_src2;

  logic              stall;
  logic [NREGS-1:0]  busy_mask;
  logic [ADDR_W:0]   pending_count;

  modport master (
    output reg_write, write_register, write_data,
    output read_register1, read_register2,
    output issue_valid, issue_writes, issue_dest, issue_src1, issue_src2,
    input  read_data1, read_data2,
    input  stall, busy_mask, pending_count
  );

  modport slave (
    input  reg_write, write_register, write_data,
    input  read_register1, read_register2,
    input  issue_valid, issue_writes, issue_dest, issue_src1, issue_src2,
    output read_data1, read_data2,
    output stall, busy_mask, pending_count
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// ----------------------------------------------------------------------------
// regfile_scoreboard
//
// This is a 32x32 integer register file with a per-register busy
// scoreboard. Register 0 always reads as zero.
//
// Ports:
//   clk  - rising-edge clock for all state
//   rst  - synchronous active-high reset. It clears the registers, the busy
//          bits and the pending count, and it takes priority over any
//          writeback or issue in the same cycle.
//   bus  - regfile_scoreboard_if.slave. It carries writeback, two
//          combinational read ports with same-cycle write bypass, the issue
//          request, the combinational stall, and the registered busy_mask
//          and pending_count.
//
// Scoreboard behaviour:
//   - A busy bit is set when a register-writing instruction is accepted at
//     issue. It is cleared when that register is written back.
//   - A writeback in the current cycle already hides the busy bit from the
//     hazard check. This lets a consumer issue in the same cycle as its
//     producer's writeback.
//   - If a register is set and cleared in the same cycle, the set wins.
//     The newly issued producer now owns the register.
// ----------------------------------------------------------------------------
module regfile_scoreboard #(
  parameter int WIDTH  = 32,
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_scoreboard_if.slave   bus
);

  localparam int CNT_W = ADDR_W + 1;

  logic [WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [CNT_W-1:0] count_q;

  logic             wb_fire;
  logic [NREGS-1:0] clear_vec;
  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] eff_busy;
  logic [NREGS-1:0] busy_next;
  logic             stall_int;
  logic             set_fire;
  logic             cnt_inc;
  logic             cnt_dec;

  // A writeback to r0 is discarded. It writes no data, clears no busy bit
  // and is never bypassed.
  assign wb_fire = bus.reg_write && (bus.write_register != '0);

  // Architectural storage. Register 0 is kept at zero because no write to
  // it is ever performed.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_fire) begin
      regs[bus.write_register] <= bus.write_data;
    end
  end

  // Read ports. r0 reads as zero first. Next, a same-cycle writeback to the
  // addressed register is forwarded. Otherwise the stored value is returned.
  always_comb begin
    bus.read_data1 = regs[bus.read_register1];
    if (bus.read_register1 == '0) begin
      bus.read_data1 = '0;
    end else if (wb_fire && (bus.write_register == bus.read_register1)) begin
      bus.read_data1 = bus.write_data;
    end
  end

  always_comb begin
    bus.read_data2 = regs[bus.read_register2];
    if (bus.read_register2 == '0) begin
      bus.read_data2 = '0;
    end else if (wb_fire && (bus.write_register == bus.read_register2)) begin
      bus.read_data2 = bus.write_data;
    end
  end

  // One-hot clear vector from the writeback. The effective busy view hides
  // a register that is being written back this cycle. This removes a
  // one-cycle bubble between producer and consumer.
  always_comb begin
    clear_vec = '0;
    if (wb_fire) begin
      clear_vec[bus.write_register] = 1'b1;
    end
    eff_busy = busy_q & ~clear_vec;
  end

  // Hazard detection. The sources check RAW hazards. The destination checks
  // WAW hazards, and only when the instruction actually writes a register.
  always_comb begin
    stall_int = 1'b0;
    if (bus.issue_valid) begin
      stall_int = eff_busy[bus.issue_src1] | eff_busy[bus.issue_src2] |
                  (bus.issue_writes & eff_busy[bus.issue_dest]);
    end
  end

  assign bus.stall = stall_int;

  // An accepted, register-writing issue claims its destination. The set is
  // OR'ed in after the clear, so the set wins on a same-register collision.
  always_comb begin
    set_fire = bus.issue_valid && !stall_int && bus.issue_writes &&
               (bus.issue_dest != '0);
    set_vec  = '0;
    if (set_fire) begin
      set_vec[bus.issue_dest] = 1'b1;
    end
    busy_next = (busy_q & ~clear_vec) | set_vec;
  end

  // The pending count tracks the popcount of busy_mask incrementally.
  // - A set adds one only when the bit was previously clear.
  // - A clear removes one only when the bit was set and is not re-claimed
  //   in the same cycle.
  always_comb begin
    cnt_inc = set_fire && !busy_q[bus.issue_dest];
    cnt_dec = wb_fire && busy_q[bus.write_register] &&
              !(set_fire && (bus.issue_dest == bus.write_register));
  end

  // Scoreboard state register. Reset takes priority over any concurrent
  // set or clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q <= busy_next;
      case ({cnt_inc, cnt_dec})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.busy_mask     = busy_q;
  assign bus.pending_count = count_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_regfile_scoreboard
//
// This is a directed, table-driven bench for regfile_scoreboard.
//
// Each table row drives one cycle of inputs and checks:
//   - the combinational outputs mid-cycle (read_data1/2, stall);
//   - the registered outputs just after the next rising edge
//     (busy_mask, pending_count).
//
// A hand-written sequence afterwards covers reset arriving in the middle of
// activity.
// ----------------------------------------------------------------------------
module tb_regfile_scoreboard;

  localparam int WIDTH  = 32;
  localparam int NREGS  = 32;
  localparam int ADDR_W = 5;

  logic clk;
  logic rst;

  int checks;
  int errors;

  regfile_scoreboard_if #(.WIDTH(WIDTH), .NREGS(NREGS), .ADDR_W(ADDR_W)) bus ();

  regfile_scoreboard #(.WIDTH(WIDTH), .NREGS(NREGS), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock with a 10-time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        iv;
    logic        iw;
    logic [4:0]  id;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [31:0] exp_rd1;
    logic [31:0] exp_rd2;
    logic        exp_stall;
    logic [31:0] exp_busy;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic applyStimulus(input vec_t v);
    bus.reg_write      = v.rw;
    bus.write_register = v.wr;
    bus.write_data     = v.wd;
    bus.read_register1 = v.r1;
    bus.read_register2 = v.r2;
    bus.issue_valid    = v.iv;
    bus.issue_writes   = v.iw;
    bus.issue_dest     = v.id;
    bus.issue_src1     = v.s1;
    bus.issue_src2     = v.s2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drives an idle cycle, except for a possible issue of dest d.
  function automatic vec_t idleVec(input string name, input logic iv,
                                   input logic [4:0] d);
    vec_t v;
    v = '{name, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, iv, iv, d, 5'd0, 5'd0,
          32'd0, 32'd0, 1'b0, 32'd0, 32'd0};
    return v;
  endfunction

  // Watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    checks = 0;
    errors = 0;

    //        name           rw wr  wd            r1 r2 iv iw id s1 s2  rd1           rd2           st busy       cnt
    vecs.push_back(vec_t'{"reset_read",  1'b0,5'd0,32'h0,        5'd5,5'd0,1'b0,1'b0,5'd0,5'd0,5'd0, 32'h0,        32'h0,        1'b0,32'h0,    32'd0});
    vecs.push_back(vec_t'{"bypass_r7",   1'b1,5'd7,32'hDEADBEEF, 5'd7,5'd0,1'b0,1'b0,5'd0,5'd0,5'd0, 32'hDEADBEEF, 32'h0,        1'b0,32'h0,    32'd0});
    vecs.push_back(vec_t'{"write_r0",    1'b1,5'd0,32'h1234,     5'd7,5'd0,1'b0,1'b0,5'd0,5'd0,5'd0, 32'hDEADBEEF, 32'h0,        1'b0,32'h0,    32'd0});
    vecs.push_back(vec_t'{"read_stored", 1'b0,5'd0,32'h0,        5'd0,5'd7,1'b0,1'b0,5'd0,5'd0,5'd0, 32'h0,        32'hDEADBEEF, 1'b0,32'h0,    32'd0});
    vecs.push_back(vec_t'{"issue_d3",    1'b0,5'd0,32'h0,        5'd0,5'd0,1'b1,1'b1,5'd3,5'd0,5'd0, 32'h0,        32'h0,        1'b0,32'h8,    32'd1});
    vecs.push_back(vec_t'{"raw_stall",   1'b0,5'd0,32'h0,        5'd0,5'd0,1'b1,1'b0,5'd0,5'd3,5'd0, 32'h0,        32'h0,        1'b1,32'h8,    32'd1});
    vecs.push_back(vec_t'{"raw_wb_pass", 1'b1,5'd3,32'h55,       5'd3,5'd0,1'b1,1'b1,5'd5,5'd3,5'd0, 32'h55,       32'h0,        1'b0,32'h20,   32'd1});
    vecs.push_back(vec_t'{"clr5_set4",   1'b1,5'd5,32'h77,       5'd5,5'd3,1'b1,1'b1,5'd4,5'd0,5'd0, 32'h77,       32'h55,       1'b0,32'h10,   32'd1});
    vecs.push_back(vec_t'{"set_wins",    1'b1,5'd4,32'h44,       5'd4,5'd5,1'b1,1'b1,5'd4,5'd0,5'd0, 32'h44,       32'h77,       1'b0,32'h10,   32'd1});
    vecs.push_back(vec_t'{"issue_d9",    1'b0,5'd0,32'h0,        5'd0,5'd0,1'b1,1'b1,5'd9,5'd0,5'd0, 32'h0,        32'h0,        1'b0,32'h210,  32'd2});
    vecs.push_back(vec_t'{"waw_stall",   1'b0,5'd0,32'h0,        5'd0,5'd0,1'b1,1'b1,5'd9,5'd1,5'd2, 32'h0,        32'h0,        1'b1,32'h210,  32'd2});
    vecs.push_back(vec_t'{"waw_nowrite", 1'b0,5'd0,32'h0,        5'd0,5'd0,1'b1,1'b0,5'd9,5'd1,5'd2, 32'h0,        32'h0,        1'b0,32'h210,  32'd2});
    vecs.push_back(vec_t'{"no_valid",    1'b0,5'd0,32'h0,        5'd0,5'd0,1'b0,1'b1,5'd9,5'd9,5'd4, 32'h0,        32'h0,        1'b0,32'h210,  32'd2});
    vecs.push_back(vec_t'{"src2_stall",  1'b0,5'd0,32'h0,        5'd0,5'd0,1'b1,1'b0,5'd0,5'd0,5'd4, 32'h0,        32'h0,        1'b1,32'h210,  32'd2});
    vecs.push_back(vec_t'{"wb_r9",       1'b1,5'd9,32'h99,       5'd9,5'd4,1'b0,1'b0,5'd0,5'd0,5'd0, 32'h99,       32'h44,       1'b0,32'h10,   32'd1});
    vecs.push_back(vec_t'{"wb_nonbusy",  1'b1,5'd6,32'h66,       5'd6,5'd9,1'b0,1'b0,5'd0,5'd0,5'd0, 32'h66,       32'h99,       1'b0,32'h10,   32'd1});
    vecs.push_back(vec_t'{"read_back",   1'b0,5'd0,32'h0,        5'd6,5'd4,1'b0,1'b0,5'd0,5'd0,5'd0, 32'h66,       32'h44,       1'b0,32'h10,   32'd1});

    // Initial reset with all inputs idle.
    rst = 1'b1;
    applyStimulus(idleVec("idle", 1'b0, 5'd0));
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", bus.busy_mask, 32'h0);
    checkOutput("reset_cnt", {26'd0, bus.pending_count}, 32'd0);
    rst = 1'b0;

    // Table-driven phase.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      #4;
      checkOutput({vecs[i].name, ".rd1"}, bus.read_data1, vecs[i].exp_rd1);
      checkOutput({vecs[i].name, ".rd2"}, bus.read_data2, vecs[i].exp_rd2);
      checkOutput({vecs[i].name, ".stall"}, {31'd0, bus.stall}, {31'd0, vecs[i].exp_stall});
      @(posedge clk);
      #1;
      checkOutput({vecs[i].name, ".busy"}, bus.busy_mask, vecs[i].exp_busy);
      checkOutput({vecs[i].name, ".cnt"}, {26'd0, bus.pending_count}, vecs[i].exp_cnt);
    end

    // Reset mid-sequence. Claim r1, r2, r3 on top of the busy r4.
    applyStimulus(idleVec("set_r1", 1'b1, 5'd1));
    @(posedge clk); #1;
    checkOutput("seq_busy_r1", bus.busy_mask, 32'h12);
    checkOutput("seq_cnt_r1", {26'd0, bus.pending_count}, 32'd2);
    applyStimulus(idleVec("set_r2", 1'b1, 5'd2));
    @(posedge clk); #1;
    checkOutput("seq_busy_r2", bus.busy_mask, 32'h16);
    checkOutput("seq_cnt_r2", {26'd0, bus.pending_count}, 32'd3);
    applyStimulus(idleVec("set_r3", 1'b1, 5'd3));
    @(posedge clk); #1;
    checkOutput("seq_busy_r3", bus.busy_mask, 32'h1E);
    checkOutput("seq_cnt_r3", {26'd0, bus.pending_count}, 32'd4);

    // Reset together with a writeback to r1 and an issue to r7.
    v = idleVec("rst_mix", 1'b1, 5'd7);
    v.rw = 1'b1;
    v.wr = 5'd1;
    v.wd = 32'hABCD;
    applyStimulus(v);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rst_busy", bus.busy_mask, 32'h0);
    checkOutput("rst_cnt", {26'd0, bus.pending_count}, 32'd0);

    // After reset, r1 and r7 read as zero, and r1 no longer stalls.
    v = idleVec("post_rst", 1'b1, 5'd0);
    v.iw = 1'b0;
    v.r1 = 5'd1;
    v.r2 = 5'd7;
    v.s1 = 5'd1;
    v.s2 = 5'd4;
    applyStimulus(v);
    #4;
    checkOutput("post_rst_rd1", bus.read_data1, 32'h0);
    checkOutput("post_rst_rd2", bus.read_data2, 32'h0);
    checkOutput("post_rst_stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
